// File: rtl/vend_pkg.sv
// Shared vending-controller types: FSM states, coin codes, default prices.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } vend_state_t;

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_5     = 2'b01;
  localparam logic [1:0] COIN_10    = 2'b10;
  localparam logic [1:0] COIN_20    = 2'b11;
  localparam logic [1:0] SEL_CANCEL = 2'd3;

  localparam int DEFAULT_PRICE_A    = 10;
  localparam int DEFAULT_PRICE_B    = 15;
  localparam int DEFAULT_PRICE_C    = 20;
  localparam int DEFAULT_MAX_CREDIT = 35;
  localparam int DEFAULT_TIMEOUT    = 1000;

  function automatic logic [5:0] coin_taka(input logic [1:0] code);
    case (code)
      COIN_5:  return 6'd5;
      COIN_10: return 6'd10;
      COIN_20: return 6'd20;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Counts consecutive idle cycles while enabled; pulses expire on the TIMEOUT-th one.
module vend_idle_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // The expiring cycle is itself idle, so it fires when count already holds TIMEOUT-1.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         count <= '0;
    else if (clear || !enable || expire) count <= '0;
    else                               count <= count + 1'b1;
  end

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: credit accumulation, dispense handshake, 5-Taka change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A    = DEFAULT_PRICE_A,
  parameter int PRICE_B    = DEFAULT_PRICE_B,
  parameter int PRICE_C    = DEFAULT_PRICE_C,
  parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       dispense_ack,
  input  logic       hopper_ack,
  output logic [5:0] credit,
  output logic       dispense_req,
  output logic [1:0] dispense_id,
  output logic       hopper_req,
  output logic       coin_reject,
  output logic       short_credit,
  output logic       busy
);

  localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);

  function automatic logic [5:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return 6'(PRICE_A);
      2'd1:    return 6'(PRICE_B);
      default: return 6'(PRICE_C);
    endcase
  endfunction

  vend_state_t state, state_n;
  logic [5:0]  credit_n, amt, price;
  logic [6:0]  sum;
  logic [1:0]  did_n;
  logic        coin_ok, expire;
  logic        dreq_n, hreq_n, reject_n, short_n, busy_n;

  assign amt     = coin_taka(coin_value);
  assign coin_ok = coin_valid && (coin_value != COIN_NONE);
  assign sum     = {1'b0, credit} + {1'b0, amt};
  assign price   = price_of(sel_id);

  vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (coin_valid || sel_valid),
    .enable (state == ST_CREDIT),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    credit_n = credit;
    dreq_n   = dispense_req;
    did_n    = dispense_id;
    hreq_n   = hopper_req;
    reject_n = 1'b0;
    short_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_ok) begin
          if ({1'b0, amt} <= MAX_C) begin
            credit_n = amt;
            state_n  = ST_CREDIT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_CREDIT: begin
        // A coin strobe always wins; a coincident selection is dropped.
        if (coin_valid) begin
          if (coin_ok) begin
            if (sum <= MAX_C) credit_n = sum[5:0];
            else              reject_n = 1'b1;
          end
        end else if (sel_valid) begin
          if (sel_id == SEL_CANCEL) begin
            state_n = ST_CHANGE;
            hreq_n  = 1'b1;
          end else if (credit >= price) begin
            credit_n = credit - price;
            did_n    = sel_id;
            dreq_n   = 1'b1;
            state_n  = ST_DISPENSE;
          end else begin
            short_n = 1'b1;
          end
        end else if (expire) begin
          state_n = ST_CHANGE;
          hreq_n  = 1'b1;
        end
      end
      ST_DISPENSE: begin
        reject_n = coin_ok;
        if (dispense_ack) begin
          dreq_n = 1'b0;
          if (credit == '0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_CHANGE;
            hreq_n  = 1'b1;
          end
        end
      end
      ST_CHANGE: begin
        reject_n = coin_ok;
        if (hopper_ack && hopper_req) begin
          if (credit > 6'd5) begin
            credit_n = credit - 6'd5;
          end else begin
            credit_n = '0;
            hreq_n   = 1'b0;
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_DISPENSE) || (state_n == ST_CHANGE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      dispense_req <= 1'b0;
      dispense_id  <= '0;
      hopper_req   <= 1'b0;
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      dispense_req <= dreq_n;
      dispense_id  <= did_n;
      hopper_req   <= hreq_n;
      coin_reject  <= reject_n;
      short_credit <= short_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_vend_controller;

  localparam int TMO = 8;
  localparam int MAXC = 35;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'b00;
  logic       dispense_ack = 1'b0;
  logic       hopper_ack = 1'b0;
  logic [5:0] credit;
  logic       dispense_req;
  logic [1:0] dispense_id;
  logic       hopper_req;
  logic       coin_reject;
  logic       short_credit;
  logic       busy;

  vend_controller #(
    .PRICE_A    (10),
    .PRICE_B    (15),
    .PRICE_C    (20),
    .MAX_CREDIT (MAXC),
    .TIMEOUT    (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .dispense_ack (dispense_ack),
    .hopper_ack   (hopper_ack),
    .credit       (credit),
    .dispense_req (dispense_req),
    .dispense_id  (dispense_id),
    .hopper_req   (hopper_req),
    .coin_reject  (coin_reject),
    .short_credit (short_credit),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 collecting, 2 vending, 3 paying change.
  int m_mode, m_credit, m_dreq, m_did, m_hreq, m_rej, m_short, m_idle;

  function automatic int price(input int id);
    return (id == 0) ? 10 : (id == 1) ? 15 : 20;
  endfunction

  function automatic int taka(input int code);
    return (code == 1) ? 5 : (code == 2) ? 10 : (code == 3) ? 20 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_dreq = 0; m_did = 0;
    m_hreq = 0; m_rej = 0; m_short = 0; m_idle = 0;
  endtask

  task automatic model_step();
    int amt;
    amt = taka(int'(coin_value));
    m_rej = 0;
    m_short = 0;
    case (m_mode)
      0: begin
        if (coin_valid && amt > 0) begin
          m_credit = amt;
          m_mode = 1;
          m_idle = 0;
        end
      end
      1: begin
        if (coin_valid || sel_valid) m_idle = 0;
        else m_idle++;
        if (coin_valid) begin
          if (amt > 0) begin
            if (m_credit + amt <= MAXC) m_credit += amt;
            else m_rej = 1;
          end
        end else if (sel_valid) begin
          if (sel_id == 2'd3) begin
            m_mode = 3; m_hreq = 1;
          end else if (m_credit >= price(int'(sel_id))) begin
            m_credit -= price(int'(sel_id));
            m_did = int'(sel_id);
            m_dreq = 1;
            m_mode = 2;
          end else begin
            m_short = 1;
          end
        end else if (m_idle == TMO) begin
          m_mode = 3; m_hreq = 1;
        end
      end
      2: begin
        if (coin_valid && amt > 0) m_rej = 1;
        if (dispense_ack) begin
          m_dreq = 0;
          if (m_credit == 0) m_mode = 0;
          else begin m_mode = 3; m_hreq = 1; end
        end
      end
      default: begin
        if (coin_valid && amt > 0) m_rej = 1;
        if (hopper_ack) begin
          m_credit = (m_credit > 5) ? m_credit - 5 : 0;
          if (m_credit == 0) begin m_hreq = 0; m_mode = 0; end
        end
      end
    endcase
    if (m_mode != 1) m_idle = 0;
  endtask

  task automatic compare_all();
    check("credit", 32'(credit), 32'(m_credit));
    check("dispense_req", 32'(dispense_req), 32'(m_dreq));
    if (m_dreq != 0) check("dispense_id", 32'(dispense_id), 32'(m_did));
    check("hopper_req", 32'(hopper_req), 32'(m_hreq));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("short_credit", 32'(short_credit), 32'(m_short));
    check("busy", 32'(busy), 32'((m_mode == 2 || m_mode == 3) ? 1 : 0));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    coin_valid = 1'b0;
    sel_valid = 1'b0;
    dispense_ack = 1'b0;
    hopper_ack = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1; coin_value = v; tick();
  endtask

  task automatic sel(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id; tick();
  endtask

  initial begin
    #2;
    apply_reset();
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 10 Taka, product 0, ack -> idle with nothing owed
    coin(2'b10);
    check("a_credit", 32'(credit), 32'd10);
    sel(2'd0);
    check("a_dreq", 32'(dispense_req), 32'd1);
    check("a_did", 32'(dispense_id), 32'd0);
    dispense_ack = 1'b1; tick();
    check("a_done_dreq", 32'(dispense_req), 32'd0);
    check("a_done_hreq", 32'(hopper_req), 32'd0);
    check("a_done_busy", 32'(busy), 32'd0);

    // 20 + 5, product 1 -> 10 change, two hopper handshakes
    coin(2'b11); coin(2'b01); sel(2'd1);
    check("b_credit", 32'(credit), 32'd10);
    check("b_did", 32'(dispense_id), 32'd1);
    dispense_ack = 1'b1; tick();
    check("b_hreq", 32'(hopper_req), 32'd1);
    hopper_ack = 1'b1; tick();
    check("b_credit5", 32'(credit), 32'd5);
    hopper_ack = 1'b1; tick();
    check("b_credit0", 32'(credit), 32'd0);
    check("b_hreq_off", 32'(hopper_req), 32'd0);
    check("b_busy", 32'(busy), 32'd0);

    // 20, 10, 10 -> third coin rejected, credit stays 30
    coin(2'b11); coin(2'b10); coin(2'b10);
    check("c_reject", 32'(coin_reject), 32'd1);
    check("c_credit", 32'(credit), 32'd30);
    tick();
    check("c_reject_pulse", 32'(coin_reject), 32'd0);
    sel(2'd3);
    for (int i = 0; i < 6; i++) begin hopper_ack = 1'b1; tick(); end
    check("c_drained", 32'(credit), 32'd0);

    // 5 Taka, product 2 -> short credit, then idle timeout to change
    coin(2'b01); sel(2'd2);
    check("d_short", 32'(short_credit), 32'd1);
    check("d_credit", 32'(credit), 32'd5);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      check("d_timeout_busy", 32'(busy), (i == TMO) ? 32'd1 : 32'd0);
    end
    check("d_hreq", 32'(hopper_req), 32'd1);
    hopper_ack = 1'b1; tick();
    check("d_credit0", 32'(credit), 32'd0);
    check("d_idle", 32'(busy), 32'd0);

    // coin + selection together, then a coin while vending
    coin(2'b10);
    coin_valid = 1'b1; coin_value = 2'b01; sel_valid = 1'b1; sel_id = 2'd0; tick();
    check("e_credit", 32'(credit), 32'd15);
    check("e_nodisp", 32'(dispense_req), 32'd0);
    sel(2'd0);
    coin(2'b10);
    check("e_reject", 32'(coin_reject), 32'd1);
    check("e_credit5", 32'(credit), 32'd5);
    dispense_ack = 1'b1; tick();

    // asynchronous reset while paying out 15
    apply_reset();
    coin(2'b10); coin(2'b01); sel(2'd3);
    check("f_hreq", 32'(hopper_req), 32'd1);
    check("f_credit", 32'(credit), 32'd15);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("f_async_credit", 32'(credit), 32'd0);
    check("f_async_hreq", 32'(hopper_req), 32'd0);
    check("f_async_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;

    // random traffic, including unsolicited acks
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        coin_valid   = ($urandom_range(0, 3) == 0);
        coin_value   = 2'($urandom_range(0, 3));
        sel_valid    = ($urandom_range(0, 4) == 0);
        sel_id       = 2'($urandom_range(0, 3));
        dispense_ack = ($urandom_range(0, 2) == 0);
        hopper_ack   = ($urandom_range(0, 2) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE_A, default 10, meaning price of product 0 in Taka.
REQ-002 SHALL have parameter PRICE_B, default 15, meaning price of product 1 in Taka.
REQ-003 SHALL have parameter PRICE_C, default 20, meaning price of product 2 in Taka.
REQ-004 SHALL have parameter MAX_CREDIT, default 35, meaning highest credit accepted in Taka.
REQ-005 SHALL have parameter TIMEOUT, default 1000, meaning idle cycles in CREDIT before automatic refund.
REQ-006 clock  input  1  single system clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 coin_valid  input  1  one-cycle strobe, coin present.
REQ-009 coin_value  input  2  01 = 5 Taka, 10 = 10 Taka, 11 = 20 Taka, 00 = ignored.
REQ-010 sel_valid  input  1  one-cycle selection strobe.
REQ-011 sel_id  input  2  0..2 = product, 3 = cancel.
REQ-012 dispense_ack  input  1  dispenser has delivered the product.
REQ-013 hopper_ack  input  1  hopper has paid one 5-Taka coin.
REQ-014 credit  output  6  current credit in Taka.
REQ-015 dispense_req  output  1  level request to dispenser.
REQ-016 dispense_id  output  2  product being dispensed; valid while dispense_req = 1.
REQ-017 hopper_req  output  1  level request for one 5-Taka coin.
REQ-018 coin_reject  output  1  one-cycle pulse, coin refused.
REQ-019 short_credit  output  1  one-cycle pulse, selection refused for insufficient credit.
REQ-020 busy  output  1  high in DISPENSE and CHANGE.

Function
REQ-021 SHALL implement states IDLE, CREDIT, DISPENSE and CHANGE.
REQ-022 IDLE: a valid coin SHALL load credit with its value and move to CREDIT; selections SHALL be ignored.
REQ-023 CREDIT: a coin SHALL add to credit when the sum is <= MAX_CREDIT; otherwise credit SHALL hold and coin_reject SHALL pulse.
REQ-024 CREDIT: a product selection with credit >= price SHALL subtract the price, set dispense_id and assert dispense_req on the next cycle, and move to DISPENSE.
REQ-025 CREDIT: a product selection with credit < price SHALL pulse short_credit and leave state and credit unchanged.
REQ-026 CREDIT: cancel SHALL move to CHANGE.
REQ-027 CREDIT: coin_valid and sel_valid in the same cycle SHALL process the coin only; the selection SHALL be dropped.
REQ-028 CREDIT: the idle timer SHALL clear on any coin or selection strobe; after TIMEOUT consecutive idle cycles the block SHALL move to CHANGE.
REQ-029 DISPENSE: dispense_req SHALL hold until sampled with dispense_ack, then deassert next cycle; the block SHALL then go to IDLE if credit = 0, otherwise to CHANGE.
REQ-030 CHANGE: hopper_req SHALL stay high while credit > 0.
REQ-031 CHANGE: each cycle with hopper_req and hopper_ack both high SHALL subtract 5 from credit.
REQ-032 CHANGE: when credit reaches 0, hopper_req SHALL deassert in the same update and the block SHALL go to IDLE.
REQ-033 In DISPENSE and CHANGE, every valid coin SHALL pulse coin_reject and selections SHALL be ignored.
REQ-034 Acks arriving without a matching request SHALL be ignored.
REQ-035 All outputs SHALL be registered.
REQ-036 credit SHALL never exceed MAX_CREDIT or underflow below 0.

Reset
REQ-037 Reset SHALL immediately force IDLE, credit = 0, all request and pulse outputs 0, and clear the timer, including mid-dispense or mid-change; pending credit is lost.

Structure
REQ-038 Package vend_pkg SHALL hold the state encoding, coin encoding constants and default prices.
REQ-039 The idle timer SHALL be sub-module vend_idle_timer, with inputs clear and enable and a one-cycle expire output.

Verification
REQ-040 10 Taka coin, select 0 -> dispense_req with id 0, ack -> IDLE, credit 0, no hopper_req.
REQ-041 Coins 20 then 5, select 1 -> credit 10 after dispense; then two hopper handshakes -> credit 0, IDLE.
REQ-042 Coins 20, 10, then 10 -> third coin rejected with one coin_reject pulse, credit stays 30.
REQ-043 Coin 5, select 2 -> short_credit pulse, credit 5, state CREDIT; with TIMEOUT = 8, after 8 idle cycles -> CHANGE, one hopper payout.
REQ-044 Coin and selection in the same cycle -> coin credited, no dispense; coin during DISPENSE -> coin_reject pulse.
REQ-045 Reset asserted while hopper_req is high with credit 15 -> all outputs 0 and IDLE immediately.
